// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: operand valid/ready and result done/ack bundle for the shift-add multiplier.
interface seq_shift_add_multiplier_if #(parameter int WIDTH = 32);
    logic                 iValid_Data;
    logic                 iSigned;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic                 iAck;
    logic                 oReady;
    logic                 oBusy;
    logic                 oDone;
    logic [2*WIDTH-1:0]   oProduct;
    modport master (output iValid_Data, iSigned, iA, iB, iAck, input oReady, oBusy, oDone, oProduct);
    modport slave  (input iValid_Data, iSigned, iA, iB, iAck, output oReady, oBusy, oDone, oProduct);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: sequential sign-magnitude shift-add multiplier with optional early exit.
module seq_shift_add_multiplier #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, prod_q;
    logic [WIDTH-1:0]   mplier_q, mplier_d, abs_a, abs_b;
    logic               neg_q, last_d, ready_q, busy_q, done_q;
    // Magnitudes fit unsigned WIDTH bits, so the most-negative operand needs no extra bit.
    always_comb begin
        abs_a    = (bus.iSigned && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
        abs_b    = (bus.iSigned && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        last_d   = (cnt_d == CW'(WIDTH)) || (EARLY_EXIT != 0 && mplier_d == '0);
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.iValid_Data) begin
                    mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                    mplier_q <= abs_b;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    neg_q    <= bus.iSigned & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
                    state_q  <= CALC;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (last_d) begin
                        prod_q  <= neg_q ? -acc_d : acc_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: if (bus.iAck) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.oReady   = ready_q;
    assign bus.oBusy    = busy_q;
    assign bus.oDone    = done_q;
    assign bus.oProduct = prod_q;
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential shift-add multiplier: control FSM, counter and datapath (multiplicand/multiplier/accumulator registers) in one block.
- Supports signed and unsigned operands, and optional early termination when the remaining multiplier bits are zero.
- Sits between an operand producer (valid/ready) and a result consumer (done/ack), as the next-generation replacement for the fixed 32-bit multiplier controller.

Parameters:
- WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
- EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier is zero; 0 = always run exactly WIDTH iterations.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- iValid_Data  input  1  operands valid; sampled only in IDLE.
- iSigned  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
- iA  input  WIDTH  multiplicand.
- iB  input  WIDTH  multiplier.
- iAck  input  1  consumer has taken the result; sampled only in DONE.
- oReady  output  1  high in IDLE.
- oBusy  output  1  high in CALC.
- oDone  output  1  high in DONE; oProduct valid while high.
- oProduct  output  2*WIDTH  result, registered and held stable throughout DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; counter, accumulator, multiplicand, multiplier and sign registers = 0.
  - oProduct = 0, oReady = 1, oBusy = 0, oDone = 0.
- States: IDLE, CALC, DONE. Encoding is 2 bits; the unused code returns to IDLE on the next edge.
- IDLE:
  - When iValid_Data = 1 at an edge, capture operands and go to CALC.
  - Capture: mcand (2*WIDTH bits) = |iA| zero-extended; mplier = |iB|; acc = 0; counter = 0; neg = iSigned & (iA[MSB] ^ iB[MSB]).
  - When iSigned = 0, the magnitude is the raw operand.
  - Most-negative operand: its magnitude 2^(WIDTH-1) is held correctly as unsigned WIDTH bits.
  - When iValid_Data = 0, stay in IDLE.
- CALC, one iteration per cycle:
  - If mplier[0] = 1, acc += mcand.
  - mcand <<= 1; mplier >>= 1; counter += 1.
  - Arithmetic is 2*WIDTH bits; no overflow is possible.
- Leave CALC for DONE after the edge where either:
  - counter reaches WIDTH, or
  - EARLY_EXIT = 1 and the shifted mplier is 0.
- On the CALC->DONE edge: oProduct = neg ? -(final acc) : final acc, two's complement over 2*WIDTH bits.
- Latency, counted from the accepting edge to oDone high:
  - EARLY_EXIT = 0: exactly WIDTH cycles.
  - EARLY_EXIT = 1: (index of the highest set bit of |iB|) + 1 cycles.
  - Minimum 1 cycle, including iB = 0.
- DONE:
  - oProduct is held.
  - iAck = 1 at an edge -> IDLE, and oDone falls.
  - iValid_Data is ignored in DONE.
  - iAck and iValid_Data both high in DONE -> go to IDLE only; the operands are not accepted on that edge.
- iAck outside DONE and iValid_Data outside IDLE have no effect; operand changes during CALC have no effect.
- Reset asserted mid-CALC or in DONE: immediate return to the reset values; the partial result is discarded.
- Counter width: clog2(WIDTH+1) bits; it never wraps.

Test Plan:
- WIDTH=8, EARLY_EXIT=0, unsigned: iA=200, iB=255 -> oDone exactly 8 cycles after accept; oProduct = 51000 (0xC738); held until iAck; back to IDLE one edge after iAck.
- WIDTH=8, signed: iA=-128, iB=-128 -> 0x4000. Then iA=-3, iB=5 -> 0xFFF1. Then iA=127, iB=-1 -> 0xFF81.
- WIDTH=8, EARLY_EXIT=1: iB=0 -> oDone after 1 cycle, product 0. iB=1 -> 1 cycle. iB=0x10, iA=3 -> 5 cycles, product 48. iB=0x80 unsigned -> 8 cycles.
- Handshake: iValid_Data pulsed during CALC and DONE -> ignored. iAck and iValid_Data high together in DONE -> IDLE with no new capture; a new op is accepted on the following edge.
- Reset low mid-CALC (cycle 3 of 8), asynchronously between edges -> outputs immediately take reset values; the next op after release computes correctly.
- WIDTH=32 random regression: 1000 signed and unsigned ops with both EARLY_EXIT settings -> oProduct matches the reference product; latency matches the formula above.
